// File: rtl/fence_pkg.sv
// Shared definitions for the fence-ordering job scheduler.
//   NPTS_DEF    : points per job (must match the engine's vector length)
//   COORD_W_DEF : coordinate width
//   state_t     : scheduler FSM encoding (S_IDLE .. S_RECOVER)
package fence_pkg;

    localparam int NPTS_DEF    = 6;
    localparam int COORD_W_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WAIT    = 3'd2,
        S_DRAIN   = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker, purely combinational.
//   req   : pending requests, one bit per client
//   ptr   : highest-priority client index (search starts here and wraps)
//   gnt   : one-hot pick, all zero when no request
//   idx   : binary index of the pick (0 when no request)
//   found : at least one request present
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            found
);

    logic [IDW-1:0] cand;

    // Walk clients ptr, ptr+1, ... (mod NREQ); the first hit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (int'(ptr) + k >= NREQ) begin
                cand = IDW'(int'(ptr) + k - NREQ);
            end else begin
                cand = IDW'(int'(ptr) + k);
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
        assign gnt[gi] = found && (idx == IDW'(gi));
    end

endmodule

// File: rtl/fence_job_scheduler.sv
// Shares one fence-ordering engine among NREQ clients.
// A round-robin grant picks one client, its NPTS points are streamed into the
// engine, and the NPTS ordered results are forwarded tagged with the client id.
// A watchdog resets the engine if it never answers.
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   req / pt_valid / pt_x / pt_y   : per-client job request and point stream
//   grant / pt_ready               : one-hot engine owner, per-client point accept
//   eng_reset / eng_give_valid /
//   eng_dataX / eng_dataY          : engine-side point interface
//   eng_ansX / eng_ansY /
//   eng_out_valid                  : engine result stream
//   res_valid / res_id / res_x /
//   res_y / res_last               : tagged result beats
//   busy / timeout_err             : status, watchdog expiry pulse
module fence_job_scheduler
    import fence_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int NPTS    = NPTS_DEF,
    parameter int COORD_W = COORD_W_DEF,
    parameter int TIMEOUT = 64,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         pt_valid,
    input  logic [NREQ*COORD_W-1:0] pt_x,
    input  logic [NREQ*COORD_W-1:0] pt_y,
    output logic [NREQ-1:0]         grant,
    output logic [NREQ-1:0]         pt_ready,
    output logic                    eng_reset,
    output logic                    eng_give_valid,
    output logic [COORD_W-1:0]      eng_dataX,
    output logic [COORD_W-1:0]      eng_dataY,
    input  logic [COORD_W-1:0]      eng_ansX,
    input  logic [COORD_W-1:0]      eng_ansY,
    input  logic                    eng_out_valid,
    output logic                    res_valid,
    output logic [IDW-1:0]          res_id,
    output logic [COORD_W-1:0]      res_x,
    output logic [COORD_W-1:0]      res_y,
    output logic                    res_last,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int CNT_W = $clog2(NPTS);
    localparam int WD_W  = $clog2(TIMEOUT);

    state_t               state_q, state_d;
    logic [NREQ-1:0]      grant_q, grant_d;
    logic [IDW-1:0]       g_idx_q, g_idx_d;
    logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     pt_cnt_q, pt_cnt_d;
    logic [CNT_W-1:0]     res_cnt_q, res_cnt_d;
    logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
    logic                 give_q, give_d;
    logic [COORD_W-1:0]   data_x_q, data_x_d, data_y_q, data_y_d;
    logic                 res_valid_q, res_valid_d;
    logic                 res_last_q, res_last_d;
    logic [IDW-1:0]       res_id_q, res_id_d;
    logic [COORD_W-1:0]   res_x_q, res_x_d, res_y_q, res_y_d;

    logic [NREQ-1:0]      arb_gnt;
    logic [IDW-1:0]       arb_idx;
    logic                 arb_found;
    logic                 accept;
    logic                 beat;
    logic [COORD_W-1:0]   sel_x, sel_y;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (req),
        .ptr   (rr_ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .found (arb_found)
    );

    // Only the granted client can be accepted, and only while loading.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign pt_ready[gi] = !reset && (state_q == S_LOAD) && grant_q[gi] && pt_valid[gi];
    end

    assign accept = |pt_ready;
    assign sel_x  = pt_x[int'(g_idx_q)*COORD_W +: COORD_W];
    assign sel_y  = pt_y[int'(g_idx_q)*COORD_W +: COORD_W];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        g_idx_d     = g_idx_q;
        rr_ptr_d    = rr_ptr_q;
        pt_cnt_d    = pt_cnt_q;
        res_cnt_d   = res_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        give_d      = 1'b0;
        data_x_d    = data_x_q;
        data_y_d    = data_y_q;
        res_valid_d = 1'b0;
        res_last_d  = 1'b0;
        res_id_d    = res_id_q;
        res_x_d     = res_x_q;
        res_y_d     = res_y_q;
        beat        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    state_d   = S_LOAD;
                    grant_d   = arb_gnt;
                    g_idx_d   = arb_idx;
                    rr_ptr_d  = (arb_idx == IDW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
                    pt_cnt_d  = '0;
                    res_cnt_d = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    give_d   = 1'b1;
                    data_x_d = sel_x;
                    data_y_d = sel_y;
                    if (pt_cnt_q == CNT_W'(NPTS - 1)) begin
                        pt_cnt_d = '0;
                        wd_cnt_d = '0;
                        state_d  = S_WAIT;
                    end else begin
                        pt_cnt_d = pt_cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                // A result arriving on the last watchdog cycle still counts.
                if (eng_out_valid) begin
                    beat      = 1'b1;
                    res_cnt_d = CNT_W'(1);
                    state_d   = S_DRAIN;
                end else if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
                    state_d = S_RECOVER;
                    grant_d = '0;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (eng_out_valid) begin
                    beat = 1'b1;
                    if (res_cnt_q == CNT_W'(NPTS - 1)) begin
                        res_last_d = 1'b1;
                        res_cnt_d  = '0;
                        grant_d    = '0;
                        state_d    = S_IDLE;
                    end else begin
                        res_cnt_d = res_cnt_q + 1'b1;
                    end
                end
            end
            S_RECOVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase

        if (beat) begin
            res_valid_d = 1'b1;
            res_id_d    = g_idx_q;
            res_x_d     = eng_ansX;
            res_y_d     = eng_ansY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            g_idx_q     <= '0;
            rr_ptr_q    <= '0;
            pt_cnt_q    <= '0;
            res_cnt_q   <= '0;
            wd_cnt_q    <= '0;
            give_q      <= 1'b0;
            data_x_q    <= '0;
            data_y_q    <= '0;
            res_valid_q <= 1'b0;
            res_last_q  <= 1'b0;
            res_id_q    <= '0;
            res_x_q     <= '0;
            res_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            g_idx_q     <= g_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            pt_cnt_q    <= pt_cnt_d;
            res_cnt_q   <= res_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            give_q      <= give_d;
            data_x_q    <= data_x_d;
            data_y_q    <= data_y_d;
            res_valid_q <= res_valid_d;
            res_last_q  <= res_last_d;
            res_id_q    <= res_id_d;
            res_x_q     <= res_x_d;
            res_y_q     <= res_y_d;
        end
    end

    assign grant          = grant_q;
    assign eng_give_valid = give_q;
    assign eng_dataX      = data_x_q;
    assign eng_dataY      = data_y_q;
    assign res_valid      = res_valid_q;
    assign res_last       = res_last_q;
    assign res_id         = res_id_q;
    assign res_x          = res_x_q;
    assign res_y          = res_y_q;
    assign busy           = (state_q != S_IDLE);
    // The engine is held in reset with the scheduler and pulsed on recovery.
    assign eng_reset      = reset || (state_q == S_RECOVER);
    assign timeout_err    = !reset && (state_q == S_RECOVER);

endmodule

// File: tb/tb_fence_job_scheduler.sv
module tb_fence_job_scheduler;

    localparam int NREQ    = 4;
    localparam int NPTS    = 6;
    localparam int W       = 8;
    localparam int TIMEOUT = 64;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req, pt_valid, grant, pt_ready;
    logic [NREQ*W-1:0]   pt_x, pt_y;
    logic                eng_reset, eng_give_valid, eng_out_valid;
    logic [W-1:0]        eng_dataX, eng_dataY, eng_ansX, eng_ansY;
    logic                res_valid, res_last, busy, timeout_err;
    logic [1:0]          res_id;
    logic [W-1:0]        res_x, res_y;

    int total = 0;
    int bad   = 0;
    int rr    = 0;

    // Expectations for the next sampled cycle.
    logic          exp_give_v = 1'b0;
    logic [W-1:0]  exp_gx, exp_gy;
    logic          exp_res_v = 1'b0;
    logic          exp_res_last = 1'b0;
    logic [1:0]    exp_res_id;
    logic [W-1:0]  exp_rx, exp_ry;
    logic          exp_to = 1'b0;

    logic          use_fixed = 1'b0;
    logic [W-1:0]  fx [6];
    logic [W-1:0]  fy [6];

    fence_job_scheduler #(.NREQ(NREQ), .NPTS(NPTS), .COORD_W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y),
        .grant(grant), .pt_ready(pt_ready), .eng_reset(eng_reset), .eng_give_valid(eng_give_valid),
        .eng_dataX(eng_dataX), .eng_dataY(eng_dataY), .eng_ansX(eng_ansX), .eng_ansY(eng_ansY),
        .eng_out_valid(eng_out_valid), .res_valid(res_valid), .res_id(res_id), .res_x(res_x),
        .res_y(res_y), .res_last(res_last), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin reference: first requester at or after rr, wrapping.
    function automatic int pick(input logic [NREQ-1:0] m);
        for (int k = 0; k < NREQ; k++) begin
            if (m[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return 0;
    endfunction

    // Advance one clock and check the registered outputs against expectations.
    task automatic cyc();
        @(posedge clk);
        #1;
        chk("give_valid", 32'(eng_give_valid), 32'(exp_give_v));
        if (exp_give_v) begin
            chk("give_x", 32'(eng_dataX), 32'(exp_gx));
            chk("give_y", 32'(eng_dataY), 32'(exp_gy));
        end
        chk("res_valid", 32'(res_valid), 32'(exp_res_v));
        if (exp_res_v) begin
            chk("res_id", 32'(res_id), 32'(exp_res_id));
            chk("res_x", 32'(res_x), 32'(exp_rx));
            chk("res_y", 32'(res_y), 32'(exp_ry));
            chk("res_last", 32'(res_last), 32'(exp_res_last));
        end else begin
            chk("res_last_quiet", 32'(res_last), 32'(0));
        end
        chk("timeout_err", 32'(timeout_err), 32'(exp_to));
        chk("eng_reset", 32'(eng_reset), 32'(exp_to | reset));
        exp_give_v   = 1'b0;
        exp_res_v    = 1'b0;
        exp_res_last = 1'b0;
        exp_to       = 1'b0;
    endtask

    // One job: request, load NPTS points, then play the engine.
    // dly >= TIMEOUT means the engine never answers.
    task automatic run_job(input logic [NREQ-1:0] rmask, input bit hold, input int gap,
                           input bit noise_all, input int dly, input int nbeats, input int rst_beat);
        int g, acc, k, j, b, fwd;
        logic [NREQ-1:0] pv;
        bit stop, last_now;
        g  = pick(rmask);
        rr = (g + 1) % NREQ;
        req = rmask;
        eng_out_valid = 1'b0;
        cyc();
        $display("job req=%b expect grant client %0d", rmask, g);
        chk("grant", 32'(grant), 32'(1) << g);
        chk("busy_load", 32'(busy), 32'(1));
        if (!hold) req = '0;

        acc = 0;
        k   = 0;
        while (acc < NPTS && k < 200) begin
            pv = noise_all ? {NREQ{1'b1}} : NREQ'($urandom);
            pv[g] = (k % gap == 0);
            for (int i = 0; i < NREQ; i++) begin
                pt_x[i*W +: W] = W'($urandom);
                pt_y[i*W +: W] = W'($urandom);
            end
            if (use_fixed) begin
                pt_x[g*W +: W] = fx[acc];
                pt_y[g*W +: W] = fy[acc];
            end
            pt_valid = pv;
            #1;
            chk("pt_ready", 32'(pt_ready), pv[g] ? (32'(1) << g) : 32'(0));
            if (pv[g]) begin
                exp_give_v = 1'b1;
                exp_gx     = pt_x[g*W +: W];
                exp_gy     = pt_y[g*W +: W];
                acc++;
            end
            cyc();
            k++;
        end
        chk("points_loaded", 32'(acc), 32'(NPTS));

        b = 0; fwd = 0; j = 0; stop = 1'b0;
        while (!stop && j < 300) begin
            pt_valid = NREQ'($urandom);
            pt_x     = NREQ*W'($urandom);
            pt_y     = NREQ*W'($urandom);
            eng_ansX = W'($urandom);
            eng_ansY = W'($urandom);
            if (dly >= TIMEOUT) begin
                eng_out_valid = 1'b0;
                if (j == TIMEOUT - 1) exp_to = 1'b1;
            end else begin
                eng_out_valid = (b < nbeats) && (j >= dly) &&
                                ((b == 0) ? (j == dly) : ($urandom_range(0, 1) == 1));
            end

            if (eng_out_valid && rst_beat != 0 && b + 1 == rst_beat) begin
                reset = 1'b1;
                #1;
                chk("eng_reset_in_reset", 32'(eng_reset), 32'(1));
                cyc();
                reset = 1'b0;
                eng_out_valid = 1'b0;
                pt_valid = '0;
                #1;
                chk("post_rst_grant", 32'(grant), 32'(0));
                chk("post_rst_busy", 32'(busy), 32'(0));
                chk("post_rst_res_valid", 32'(res_valid), 32'(0));
                chk("post_rst_give", 32'(eng_give_valid), 32'(0));
                chk("post_rst_res_x", 32'(res_x), 32'(0));
                chk("post_rst_eng_reset", 32'(eng_reset), 32'(0));
                chk("post_rst_pt_ready", 32'(pt_ready), 32'(0));
                rr = 0;
                return;
            end

            #1;
            chk("pt_ready_not_loading", 32'(pt_ready), 32'(0));
            if (eng_out_valid) begin
                b++;
                if (fwd < NPTS) begin
                    exp_res_v    = 1'b1;
                    exp_res_id   = 2'(g);
                    exp_rx       = eng_ansX;
                    exp_ry       = eng_ansY;
                    exp_res_last = (fwd == NPTS - 1);
                    fwd++;
                end
            end
            last_now = exp_res_last;
            cyc();
            if (last_now) begin
                chk("grant_after_last", 32'(grant), 32'(0));
                chk("busy_after_last", 32'(busy), 32'(0));
            end
            if (dly >= TIMEOUT && j == TIMEOUT - 1) chk("busy_recover", 32'(busy), 32'(1));
            if (dly >= TIMEOUT && j == TIMEOUT) begin
                chk("busy_after_timeout", 32'(busy), 32'(0));
                chk("grant_after_timeout", 32'(grant), 32'(0));
                stop = 1'b1;
            end
            if (dly < TIMEOUT && b == nbeats) stop = 1'b1;
            j++;
        end
        chk("engine_phase_done", 32'(stop), 32'(1));
        chk("results_forwarded", 32'(fwd), (dly >= TIMEOUT) ? 32'(0) : 32'(NPTS));
        eng_out_valid = 1'b0;
    endtask

    initial begin
        fx = '{8'd1, 8'd5, 8'd5, 8'd1, 8'd3, 8'd0};
        fy = '{8'd1, 8'd1, 8'd5, 8'd5, 8'd0, 8'd3};
        reset = 1'b1; req = '0; pt_valid = '0; pt_x = '0; pt_y = '0;
        eng_ansX = '0; eng_ansY = '0; eng_out_valid = 1'b0;

        // Reset state
        repeat (3) cyc();
        chk("rst_grant", 32'(grant), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_res_x", 32'(res_x), 32'(0));
        chk("rst_res_id", 32'(res_id), 32'(0));
        chk("rst_data_x", 32'(eng_dataX), 32'(0));
        chk("rst_eng_reset", 32'(eng_reset), 32'(1));
        pt_valid = '1;
        req = '1;
        #1;
        chk("rst_pt_ready", 32'(pt_ready), 32'(0));
        pt_valid = '0;
        req = '0;
        reset = 1'b0;
        cyc();
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_grant", 32'(grant), 32'(0));

        // Single job with fixed points
        use_fixed = 1'b1;
        run_job(4'b0001, 1'b0, 1, 1'b0, 5, 6, 0);
        use_fixed = 1'b0;
        // Gapped client 2, client 0 chattering every cycle
        run_job(4'b0100, 1'b0, 3, 1'b1, 3, 6, 0);
        // Engine never answers: watchdog
        run_job(4'b0010, 1'b0, 1, 1'b0, TIMEOUT, 6, 0);
        // First answer on the last watchdog cycle
        run_job(4'b1000, 1'b0, 1, 1'b0, TIMEOUT - 1, 6, 0);
        // Immediate answer, excess engine beats
        run_job(4'b1001, 1'b0, 2, 1'b0, 0, 8, 0);
        // Randomised jobs
        for (int n = 0; n < 6; n++) begin
            run_job(NREQ'($urandom_range(1, 15)), 1'b0, $urandom_range(1, 3), 1'b0,
                    $urandom_range(0, 20), 6, 0);
        end
        // Reset during the third result beat
        run_job(4'b0110, 1'b0, 1, 1'b0, 4, 6, 3);
        // Fairness with all clients requesting continuously
        for (int n = 0; n < 8; n++) begin
            run_job(4'b1111, 1'b1, 1, 1'b0, $urandom_range(0, 10), 6, 0);
        end
        req = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
